// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory stage.
//   acc_t      : per-cycle access classification from the core's SRAM-style strobes
//   DMEM_AW/DW : word-address and data widths of the core interface
//   wb_entry_t : one write-through FIFO entry {addr, data}
package dmem_pkg;

  localparam int unsigned DMEM_AW = 7;
  localparam int unsigned DMEM_DW = 32;

  typedef enum logic [1:0] {
    ACC_IDLE  = 2'd0,
    ACC_READ  = 2'd1,
    ACC_WRITE = 2'd2
  } acc_t;

  typedef struct packed {
    logic [DMEM_AW-1:0] addr;
    logic [DMEM_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/dmem_wb_fifo.sv
// Write-through FIFO carrying stores to the backing/trace bus.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset (empties the FIFO)
//   push                : enqueue {push_addr, push_data}
//   push_addr/push_data : entry to enqueue
//   pop_ready           : downstream accepts the head (ignored while empty)
//   head_valid          : FIFO not empty
//   head_addr/head_data : head entry, zero while empty
//   count               : number of stored entries
//   overflow            : one-cycle pulse when a push is dropped because the FIFO is full
module dmem_wb_fifo
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DMEM_AW-1:0]       push_addr,
  input  logic [DMEM_DW-1:0]       push_data,
  input  logic                     pop_ready,
  output logic                     head_valid,
  output logic [DMEM_AW-1:0]       head_addr,
  output logic [DMEM_DW-1:0]       head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  wb_entry_t       store [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            empty;
  logic            full;
  logic            pop;
  logic            accept;
  wb_entry_t       head;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign pop      = ~empty & pop_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign accept   = push & (~full | pop);
  assign overflow = push & full & ~pop;

  always_comb begin
    head = '0;
    if (!empty) head = store[rd_ptr];
  end

  assign head_valid = ~empty;
  assign head_addr  = head.addr;
  assign head_data  = head.data;

  // Entry storage needs no reset: it is only observed through a non-empty head.
  always_ff @(posedge clk) begin
    if (accept) store[wr_ptr] <= '{addr: push_addr, data: push_data};
  end

  // Pointers are PW bits wide, so increments wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_unit.sv
// Data-memory stage behind the single-cycle MIPS core.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   CEN, WEN, OEN         : active-low chip/write/output enables from the core
//   A, Data2Mem           : word address and store data
//   ReadDataMem           : combinational load data (zero unless reading)
//   wb_valid/wb_ready     : write-through FIFO head handshake
//   wb_addr/wb_data       : FIFO head entry (zero while empty)
//   occupancy             : FIFO entry count
//   ovf, clr_ovf          : sticky dropped-store flag and its clear
//   load_cnt, store_cnt   : saturating access counters
module data_mem_unit
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned WORDS = 128
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    CEN,
  input  logic                    WEN,
  input  logic                    OEN,
  input  logic [DMEM_AW-1:0]      A,
  input  logic [DMEM_DW-1:0]      Data2Mem,
  output logic [DMEM_DW-1:0]      ReadDataMem,
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output logic [DMEM_AW-1:0]      wb_addr,
  output logic [DMEM_DW-1:0]      wb_data,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic                    ovf,
  input  logic                    clr_ovf,
  output logic [CNT_W-1:0]        load_cnt,
  output logic [CNT_W-1:0]        store_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DMEM_DW-1:0] mem [WORDS];
  acc_t               acc;
  logic               wr;
  logic               rd;
  logic               overflow;

  // WEN low wins over OEN low: such a cycle is a write with no read.
  always_comb begin
    acc = ACC_IDLE;
    if (!CEN) begin
      if (!WEN)      acc = ACC_WRITE;
      else if (!OEN) acc = ACC_READ;
    end
  end

  assign wr = (acc == ACC_WRITE);
  assign rd = (acc == ACC_READ);

  always_comb begin
    ReadDataMem = '0;
    if (rd) ReadDataMem = mem[A];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < WORDS; i++) mem[i] <= '0;
    end else if (wr) begin
      mem[A] <= Data2Mem;
    end
  end

  dmem_wb_fifo #(
    .DEPTH(DEPTH)
  ) u_wb_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr),
    .push_addr (A),
    .push_data (Data2Mem),
    .pop_ready (wb_ready),
    .head_valid(wb_valid),
    .head_addr (wb_addr),
    .head_data (wb_data),
    .count     (occupancy),
    .overflow  (overflow)
  );

  // Set has priority over clear when both land in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)          ovf <= 1'b0;
    else if (overflow)   ovf <= 1'b1;
    else if (clr_ovf)    ovf <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_cnt  <= '0;
      store_cnt <= '0;
    end else begin
      if (rd && load_cnt != CNT_MAX)  load_cnt  <= load_cnt + 1'b1;
      if (wr && store_cnt != CNT_MAX) store_cnt <= store_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
module tb_data_mem_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        CEN, WEN, OEN;
  logic [6:0]  A;
  logic [31:0] Data2Mem;
  logic [31:0] ReadDataMem;
  logic        wb_valid;
  logic        wb_ready;
  logic [6:0]  wb_addr;
  logic [31:0] wb_data;
  logic [2:0]  occupancy;
  logic        ovf;
  logic        clr_ovf;
  logic [15:0] load_cnt;
  logic [15:0] store_cnt;

  int tests = 0;
  int fails = 0;
  logic [38:0] sb [$];

  data_mem_unit #(
    .DEPTH(4),
    .CNT_W(16),
    .WORDS(128)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .CEN        (CEN),
    .WEN        (WEN),
    .OEN        (OEN),
    .A          (A),
    .Data2Mem   (Data2Mem),
    .ReadDataMem(ReadDataMem),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .occupancy  (occupancy),
    .ovf        (ovf),
    .clr_ovf    (clr_ovf),
    .load_cnt   (load_cnt),
    .store_cnt  (store_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [38:0] act, input logic [38:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    CEN = 1'b1; WEN = 1'b1; OEN = 1'b1;
  endtask

  task automatic do_store(input logic [6:0] a, input logic [31:0] d, input bit expect_push);
    CEN = 1'b0; WEN = 1'b0; OEN = 1'b1; A = a; Data2Mem = d;
    if (expect_push) sb.push_back({a, d});
  endtask

  task automatic do_load(input logic [6:0] a);
    CEN = 1'b0; WEN = 1'b1; OEN = 1'b0; A = a;
  endtask

  // Monitor: every accepted handshake must match the oldest expected store.
  initial begin
    logic [38:0] exp_e;
    forever begin
      @(negedge clk);
      if (rst_n && wb_valid && wb_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL wb_unexpected: got %h expected none", {wb_addr, wb_data});
        end else begin
          exp_e = sb.pop_front();
          chk("wb_entry", {wb_addr, wb_data}, exp_e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; idle(); A = '0; Data2Mem = '0; wb_ready = 1'b0; clr_ovf = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_occ", 39'(occupancy), 39'd0);
    chk("rst_valid", 39'(wb_valid), 39'd0);
    chk("rst_wb", {wb_addr, wb_data}, 39'd0);
    chk("rst_ovf", 39'(ovf), 39'd0);
    chk("rst_cnts", {7'd0, load_cnt, store_cnt}, 39'd0);

    // 1: load from cleared memory
    do_load(7'd5);
    #1 chk("t1_rdata", 39'(ReadDataMem), 39'd0);
    tick(); idle();
    chk("t1_load_cnt", 39'(load_cnt), 39'd1);
    chk("t1_valid", 39'(wb_valid), 39'd0);

    // 2: store then load same address; no FIFO bypass
    do_store(7'd3, 32'hDEADBEEF, 1'b1);
    #1 chk("t2_no_bypass", 39'(wb_valid), 39'd0);
    tick();
    do_load(7'd3);
    #1 chk("t2_rdata", 39'(ReadDataMem), 39'(32'hDEADBEEF));
    chk("t2_valid", 39'(wb_valid), 39'd1);
    chk("t2_occ", 39'(occupancy), 39'd1);
    tick(); idle();
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    chk("t2_drained", 39'(occupancy), 39'd0);

    // 3: five stores into a stalled FIFO; the fifth is dropped
    for (int i = 0; i < 5; i++) begin
      do_store(7'(i), 32'h10 + 32'(i), i < 4);
      tick();
    end
    idle();
    chk("t3_occ", 39'(occupancy), 39'd4);
    chk("t3_ovf", 39'(ovf), 39'd1);
    chk("t3_store_cnt", 39'(store_cnt), 39'd6);
    do_load(7'd4);
    #1 chk("t3_mem4", 39'(ReadDataMem), 39'h14);
    tick(); idle();
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    wb_ready = 1'b0;
    chk("t3_empty", 39'(wb_valid), 39'd0);
    chk("t3_sb_empty", 39'(sb.size()), 39'd0);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t3_clr", 39'(ovf), 39'd0);

    // 4: full FIFO, simultaneous push and pop
    for (int i = 0; i < 4; i++) begin
      do_store(7'(8 + i), 32'h20 + 32'(i), 1'b1);
      tick();
    end
    do_store(7'd7, 32'hAA, 1'b1);
    wb_ready = 1'b1;
    tick(); idle();
    wb_ready = 1'b0;
    chk("t4_occ", 39'(occupancy), 39'd4);
    chk("t4_ovf", 39'(ovf), 39'd0);
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    wb_ready = 1'b0;
    chk("t4_empty", 39'(wb_valid), 39'd0);
    chk("t4_sb_empty", 39'(sb.size()), 39'd0);

    // 5: overflow and clear in the same cycle; set wins
    for (int i = 0; i < 4; i++) begin
      do_store(7'(i), 32'h30 + 32'(i), 1'b1);
      tick();
    end
    do_store(7'd4, 32'h34, 1'b0);
    clr_ovf = 1'b1;
    tick(); idle();
    clr_ovf = 1'b0;
    chk("t5_ovf_set", 39'(ovf), 39'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t5_ovf_clr", 39'(ovf), 39'd0);
    chk("t5_cnts", {7'd0, load_cnt, store_cnt}, {7'd0, 16'd3, 16'd16});

    // 6: reset with entries pending and an active access
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    chk("t6_occ3", 39'(occupancy), 39'd3);
    rst_n = 1'b0;
    sb.delete();
    do_store(7'd3, 32'h55, 1'b0);
    wb_ready = 1'b1;
    tick();
    rst_n = 1'b1; idle(); wb_ready = 1'b0;
    chk("t6_occ", 39'(occupancy), 39'd0);
    chk("t6_valid", 39'(wb_valid), 39'd0);
    chk("t6_cnts", {7'd0, load_cnt, store_cnt}, 39'd0);
    chk("t6_ovf", 39'(ovf), 39'd0);
    do_load(7'd3);
    #1 chk("t6_rdata3", 39'(ReadDataMem), 39'd0);
    tick();
    do_load(7'd0);
    #1 chk("t6_rdata0", 39'(ReadDataMem), 39'd0);
    tick(); idle();
    chk("t6_load_cnt", 39'(load_cnt), 39'd2);
    tick();
    chk("final_sb_empty", 39'(sb.size()), 39'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
